// File: rtl/washing_machine_pkg.sv
// Shared types, state encoding and phase-duration table for the washing machine controller.
package washing_machine_pkg;

  // Seconds counter width; the longest phase (1500 s) fits in 11 bits.
  localparam int unsigned SecW = 11;

  // One-hot controller state, exported directly on o_state.
  typedef enum logic [5:0] {
    StIdle  = 6'b000001,
    StReady = 6'b000010,
    StSoak  = 6'b000100,
    StWash  = 6'b001000,
    StRinse = 6'b010000,
    StSpin  = 6'b100000
  } wm_state_e;

  // Timed phases, used as the column index into the duration table.
  typedef enum logic [1:0] {
    PhSoak  = 2'd0,
    PhWash  = 2'd1,
    PhRinse = 2'd2,
    PhSpin  = 2'd3
  } wm_phase_e;

  // Phase durations in seconds, rows by load mode, columns soak/wash/rinse/spin.
  localparam logic [SecW-1:0] DurTable [4][4] = '{
    '{11'd300, 11'd600,  11'd300, 11'd300},
    '{11'd480, 11'd900,  11'd480, 11'd480},
    '{11'd600, 11'd1200, 11'd600, 11'd600},
    '{11'd720, 11'd1500, 11'd720, 11'd720}
  };

  // Duration in seconds of the given phase for the given load mode.
  function automatic logic [SecW-1:0] phase_duration(input logic [1:0] mode,
                                                     input wm_phase_e phase);
    return DurTable[mode][phase];
  endfunction

  // Index of the lowest set bit of a mode select; 0 when nothing is set.
  function automatic logic [1:0] lowest_mode(input logic [3:0] sel);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (sel[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wm_phase_timer.sv
// Shared phase timer: a prescaler dividing i_clk down to seconds and a
// seconds-remaining counter that can be loaded, held, or cleared.
module wm_phase_timer
  import washing_machine_pkg::*;
#(
  parameter int unsigned CLK_HZ = 250
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_clear,
  input  logic            i_load,
  input  logic [SecW-1:0] i_load_val,
  input  logic            i_hold,
  output logic [SecW-1:0] o_sec_left,
  output logic            o_expire
);

  localparam int unsigned PrescW = $clog2(CLK_HZ);
  localparam logic [PrescW-1:0] PrescMax = PrescW'(CLK_HZ - 1);

  logic [PrescW-1:0] presc_q, presc_d;
  logic [SecW-1:0]   sec_q, sec_d;
  logic              tick;

  // A tick only fires on a running, non-empty counter; hold suppresses it.
  assign tick     = !i_hold && (presc_q == PrescMax) && (sec_q != '0);
  assign o_expire = tick && (sec_q == SecW'(1));
  assign o_sec_left = sec_q;

  // Next-state: clear beats load, load beats hold, hold beats counting.
  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    if (i_clear) begin
      presc_d = '0;
      sec_d   = '0;
    end else if (i_load) begin
      presc_d = '0;
      sec_d   = i_load_val;
    end else if (!i_hold) begin
      if (presc_q == PrescMax) begin
        presc_d = '0;
        if (tick) sec_d = sec_q - SecW'(1);
      end else begin
        presc_d = presc_q + PrescW'(1);
      end
    end
  end

  // Timer registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      presc_q <= '0;
      sec_q   <= '0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
    end
  end

endmodule

// File: rtl/washing_machine_ctrl.sv
// Coin-operated washing machine sequencer: IDLE/READY gating, then
// SOAK -> WASH -> RINSE (xRINSE_CYCLES) -> SPIN timed by one shared timer.
module washing_machine_ctrl
  import washing_machine_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 250,
  parameter int unsigned N_MODES      = 4,
  parameter int unsigned RINSE_CYCLES = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_coin,
  input  logic               i_lid,
  input  logic               i_start,
  input  logic               i_cancel,
  input  logic [N_MODES-1:0] i_mode,
  output logic [5:0]         o_state,
  output logic               o_waterinlet,
  output logic               o_motor,
  output logic               o_door_lock,
  output logic               o_paused,
  output logic               o_coinreturn,
  output logic               o_done,
  output logic [SecW-1:0]    o_sec_left,
  output logic [1:0]         o_rinse_idx
);

  localparam logic [1:0] RinseLast = 2'(RINSE_CYCLES - 1);

  wm_state_e       state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic [1:0]      rinse_q, rinse_d;
  logic            coin_ret_q, coin_ret_d;
  logic            done_q, done_d;

  logic [3:0]      mode_ext;
  logic            wet_phase;
  logic            paused;
  logic            timer_load;
  logic            timer_clear;
  logic            timer_expire;
  wm_phase_e       load_phase;
  logic [SecW-1:0] load_val;
  logic [SecW-1:0] sec_left;

  assign mode_ext  = 4'(i_mode);
  assign wet_phase = (state_q == StSoak) || (state_q == StWash) || (state_q == StRinse);
  // Spin keeps the door latched, so an open lid only freezes the wet phases.
  assign paused    = wet_phase && i_lid;
  // mode_d carries the freshly latched mode on the READY->SOAK edge.
  assign load_val  = phase_duration(mode_d, load_phase);

  wm_phase_timer #(
    .CLK_HZ (CLK_HZ)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    (timer_clear),
    .i_load     (timer_load),
    .i_load_val (load_val),
    .i_hold     (paused),
    .o_sec_left (sec_left),
    .o_expire   (timer_expire)
  );

  // Next-state, mode latch, rinse index and timer control; cancel wins over everything.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    rinse_d     = rinse_q;
    coin_ret_d  = 1'b0;
    done_d      = 1'b0;
    timer_load  = 1'b0;
    load_phase  = PhSoak;
    unique case (state_q)
      StIdle: begin
        if (i_coin && !i_lid && !i_cancel) state_d = StReady;
      end
      StReady: begin
        if (i_cancel) begin
          state_d    = StIdle;
          coin_ret_d = 1'b1;
        end else if (i_start && !i_lid && (mode_ext != 4'd0)) begin
          state_d    = StSoak;
          mode_d     = lowest_mode(mode_ext);
          timer_load = 1'b1;
          load_phase = PhSoak;
        end
      end
      StSoak: begin
        if (i_cancel) begin
          state_d = StIdle;
        end else if (timer_expire) begin
          state_d    = StWash;
          timer_load = 1'b1;
          load_phase = PhWash;
        end
      end
      StWash: begin
        if (i_cancel) begin
          state_d = StIdle;
        end else if (timer_expire) begin
          state_d    = StRinse;
          rinse_d    = 2'd0;
          timer_load = 1'b1;
          load_phase = PhRinse;
        end
      end
      StRinse: begin
        if (i_cancel) begin
          state_d = StIdle;
        end else if (timer_expire) begin
          timer_load = 1'b1;
          if (rinse_q == RinseLast) begin
            state_d    = StSpin;
            load_phase = PhSpin;
          end else begin
            // Re-enter RINSE for the next pass with a fresh duration.
            rinse_d    = rinse_q + 2'd1;
            load_phase = PhRinse;
          end
        end
      end
      StSpin: begin
        if (i_cancel) begin
          state_d = StIdle;
        end else if (timer_expire) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_d != StRinse) rinse_d = 2'd0;
    // Outside the timed phases the counter sits at zero.
    timer_clear = (state_d == StIdle) || (state_d == StReady);
  end

  // State, latched mode, rinse pass and one-cycle pulse registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      mode_q     <= 2'd0;
      rinse_q    <= 2'd0;
      coin_ret_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      rinse_q    <= rinse_d;
      coin_ret_q <= coin_ret_d;
      done_q     <= done_d;
    end
  end

  // Outputs decoded from state; forced to reset values while i_rst is high.
  always_comb begin
    o_state      = state_q;
    o_waterinlet = wet_phase && !i_lid;
    o_motor      = ((state_q == StWash) || (state_q == StRinse)) && !i_lid
                   || (state_q == StSpin);
    o_door_lock  = (state_q == StSpin);
    o_paused     = paused;
    o_coinreturn = coin_ret_q;
    o_done       = done_q;
    o_sec_left   = sec_left;
    o_rinse_idx  = rinse_q;
    if (i_rst) begin
      o_state      = StIdle;
      o_waterinlet = 1'b0;
      o_motor      = 1'b0;
      o_door_lock  = 1'b0;
      o_paused     = 1'b0;
      o_coinreturn = 1'b0;
      o_done       = 1'b0;
      o_sec_left   = '0;
      o_rinse_idx  = 2'd0;
    end
  end

endmodule

// File: tb/tb_washing_machine_ctrl.sv
// Scoreboard bench for washing_machine_ctrl: stimulus queues the expected
// state transitions, a monitor pops and compares them as the DUT moves.
module tb_washing_machine_ctrl;

  localparam int unsigned ClkHz       = 2;
  localparam int unsigned NModes      = 4;
  localparam int unsigned RinseCycles = 2;

  localparam logic [5:0] SIdle  = 6'b000001;
  localparam logic [5:0] SReady = 6'b000010;
  localparam logic [5:0] SSoak  = 6'b000100;
  localparam logic [5:0] SWash  = 6'b001000;
  localparam logic [5:0] SRinse = 6'b010000;
  localparam logic [5:0] SSpin  = 6'b100000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        coin = 1'b0;
  logic        lid = 1'b0;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic [3:0]  mode = 4'd0;

  logic [5:0]  o_state;
  logic        o_waterinlet, o_motor, o_door_lock, o_paused, o_coinreturn, o_done;
  logic [10:0] o_sec_left;
  logic [1:0]  o_rinse_idx;

  washing_machine_ctrl #(
    .CLK_HZ       (ClkHz),
    .N_MODES      (NModes),
    .RINSE_CYCLES (RinseCycles)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_coin       (coin),
    .i_lid        (lid),
    .i_start      (start),
    .i_cancel     (cancel),
    .i_mode       (mode),
    .o_state      (o_state),
    .o_waterinlet (o_waterinlet),
    .o_motor      (o_motor),
    .o_door_lock  (o_door_lock),
    .o_paused     (o_paused),
    .o_coinreturn (o_coinreturn),
    .o_done       (o_done),
    .o_sec_left   (o_sec_left),
    .o_rinse_idx  (o_rinse_idx)
  );

  initial forever #5 clk = ~clk;

  // from-state fields: len, paused, viol; to-state fields: the rest.
  typedef struct {
    logic [5:0] from_s;
    logic [5:0] to_s;
    bit         chk_len;
    int         len;
    int         sec0;
    int         ridx;
    int         done;
    int         cret;
    int         valve;
    int         motor;
    int         lock;
    int         paused;
    int         viol;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_err = 0;
  int  cret_cycles = 0;
  int  done_cycles = 0;
  int  ev_idx = 0;
  bit  mon_en = 1'b0;

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, req);
    end
  endtask

  // Entry outputs assume the lid is closed when the new state begins.
  task automatic push_ev(input logic [5:0] from_s, input logic [5:0] to_s, input bit chk_len,
                         input int len, input int sec0, input int ridx, input int done,
                         input int cret, input int paused);
    ev_t e;
    e.from_s  = from_s;
    e.to_s    = to_s;
    e.chk_len = chk_len;
    e.len     = len;
    e.sec0    = sec0;
    e.ridx    = ridx;
    e.done    = done;
    e.cret    = cret;
    e.valve   = (to_s == SSoak || to_s == SWash || to_s == SRinse) ? 1 : 0;
    e.motor   = (to_s == SWash || to_s == SRinse || to_s == SSpin) ? 1 : 0;
    e.lock    = (to_s == SSpin) ? 1 : 0;
    e.paused  = paused;
    e.viol    = 0;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_state(input string nm, input logic [5:0] s, input logic [1:0] r,
                            input int budget);
    int n;
    n = 0;
    while (!(o_state == s && o_rinse_idx == r) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, (o_state == s && o_rinse_idx == r) ? 1 : 0, 1);
  endtask

  // Monitor: a change of state or rinse pass is one observed event.
  initial begin
    logic [5:0]  pst;
    logic [1:0]  pri;
    logic        ppau;
    logic [10:0] psec;
    int          len, pcnt, viol;
    ev_t         e;
    pst = SIdle; pri = 2'd0; ppau = 1'b0; psec = 11'd0;
    len = 0; pcnt = 0; viol = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (o_state != pst || o_rinse_idx != pri) begin
          chk($sformatf("ev%0d.expected", ev_idx), (exp_q.size() > 0) ? 1 : 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("ev%0d.from", ev_idx), int'(pst), int'(e.from_s));
            chk($sformatf("ev%0d.to", ev_idx), int'(o_state), int'(e.to_s));
            if (e.chk_len) chk($sformatf("ev%0d.len", ev_idx), len, e.len);
            chk($sformatf("ev%0d.paused_cycles", ev_idx), pcnt, e.paused);
            chk($sformatf("ev%0d.violations", ev_idx), viol, e.viol);
            chk($sformatf("ev%0d.sec_left", ev_idx), int'(o_sec_left), e.sec0);
            chk($sformatf("ev%0d.rinse_idx", ev_idx), int'(o_rinse_idx), e.ridx);
            chk($sformatf("ev%0d.done", ev_idx), int'(o_done), e.done);
            chk($sformatf("ev%0d.coinreturn", ev_idx), int'(o_coinreturn), e.cret);
            chk($sformatf("ev%0d.valve", ev_idx), int'(o_waterinlet), e.valve);
            chk($sformatf("ev%0d.motor", ev_idx), int'(o_motor), e.motor);
            chk($sformatf("ev%0d.door_lock", ev_idx), int'(o_door_lock), e.lock);
          end
          ev_idx++;
          len = 0; pcnt = 0; viol = 0;
        end
        len++;
        if (o_paused) pcnt++;
        if (o_paused && (o_waterinlet || o_motor)) viol++;
        if (o_paused && ppau && o_sec_left != psec) viol++;
        if (o_state == SSpin && (!o_door_lock || o_paused || !o_motor)) viol++;
        if (o_coinreturn) cret_cycles++;
        if (o_done) done_cycles++;
      end
      pst = o_state; pri = o_rinse_idx; ppau = o_paused; psec = o_sec_left;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want run to finish");
    $fatal(1);
  end

  initial begin
    // Reset state.
    step(3);
    chk("rst.state", int'(o_state), int'(SIdle));
    chk("rst.sec_left", int'(o_sec_left), 0);
    chk("rst.outputs", int'({o_waterinlet, o_motor, o_door_lock, o_paused,
                             o_coinreturn, o_done, o_rinse_idx}), 0);
    rst = 1'b0;
    step(1);
    mon_en = 1'b1;

    // Coin with the lid open is ignored.
    lid = 1'b1; coin = 1'b1;
    step(3);
    coin = 1'b0; lid = 1'b0;
    step(2);
    chk("lid_coin.state", int'(o_state), int'(SIdle));

    // Coin then cancel in READY returns the coin for one cycle.
    push_ev(SIdle, SReady, 0, 0, 0, 0, 0, 0, 0);
    push_ev(SReady, SIdle, 0, 0, 0, 0, 0, 1, 0);
    coin = 1'b1; step(1); coin = 1'b0;
    step(3);
    cancel = 1'b1; step(1); cancel = 1'b0;
    step(3);

    // Full mode0 run with two rinse passes.
    push_ev(SIdle, SReady, 0, 0, 0, 0, 0, 0, 0);
    push_ev(SReady, SSoak, 0, 0, 300, 0, 0, 0, 0);
    push_ev(SSoak, SWash, 1, 600, 600, 0, 0, 0, 0);
    push_ev(SWash, SRinse, 1, 1200, 300, 0, 0, 0, 0);
    push_ev(SRinse, SRinse, 1, 600, 300, 1, 0, 0, 0);
    push_ev(SRinse, SSpin, 1, 600, 300, 0, 0, 0, 0);
    push_ev(SSpin, SIdle, 1, 600, 0, 0, 1, 0, 0);
    coin = 1'b1; step(1); coin = 1'b0;
    mode = 4'b0001; start = 1'b1; step(1); start = 1'b0;
    wait_state("run0.reach_spin", SSpin, 2'd0, 5000);
    wait_state("run0.reach_idle", SIdle, 2'd0, 2000);
    step(3);

    // Mode2 run: lid open 37 cycles mid-WASH, and again during SPIN.
    push_ev(SIdle, SReady, 0, 0, 0, 0, 0, 0, 0);
    push_ev(SReady, SSoak, 0, 0, 600, 0, 0, 0, 0);
    push_ev(SSoak, SWash, 1, 1200, 1200, 0, 0, 0, 0);
    push_ev(SWash, SRinse, 1, 2437, 600, 0, 0, 0, 37);
    push_ev(SRinse, SRinse, 1, 1200, 600, 1, 0, 0, 0);
    push_ev(SRinse, SSpin, 1, 1200, 600, 0, 0, 0, 0);
    push_ev(SSpin, SIdle, 1, 1200, 0, 0, 1, 0, 0);
    coin = 1'b1; step(1); coin = 1'b0;
    mode = 4'b0100; start = 1'b1; step(1); start = 1'b0;
    wait_state("run2.reach_wash", SWash, 2'd0, 3000);
    step(100);
    lid = 1'b1; step(37); lid = 1'b0;
    wait_state("run2.reach_spin", SSpin, 2'd0, 6000);
    step(50);
    lid = 1'b1; step(100); lid = 1'b0;
    wait_state("run2.reach_idle", SIdle, 2'd0, 2000);
    step(3);

    // Mode select 0110 latches mode1; later change and stray coin are ignored; cancel in WASH.
    push_ev(SIdle, SReady, 0, 0, 0, 0, 0, 0, 0);
    push_ev(SReady, SSoak, 0, 0, 480, 0, 0, 0, 0);
    push_ev(SSoak, SWash, 1, 960, 900, 0, 0, 0, 0);
    push_ev(SWash, SIdle, 0, 0, 0, 0, 0, 0, 0);
    coin = 1'b1; step(1); coin = 1'b0;
    mode = 4'b0110; start = 1'b1; step(1); start = 1'b0;
    step(200);
    mode = 4'b1000; coin = 1'b1; step(1); coin = 1'b0;
    wait_state("mode.reach_wash", SWash, 2'd0, 2000);
    step(10);
    cancel = 1'b1; step(1); cancel = 1'b0;
    step(3);

    // Reset mid-RINSE with cancel held: plain IDLE, no pulses.
    push_ev(SIdle, SReady, 0, 0, 0, 0, 0, 0, 0);
    push_ev(SReady, SSoak, 0, 0, 300, 0, 0, 0, 0);
    push_ev(SSoak, SWash, 1, 600, 600, 0, 0, 0, 0);
    push_ev(SWash, SRinse, 1, 1200, 300, 0, 0, 0, 0);
    push_ev(SRinse, SIdle, 0, 0, 0, 0, 0, 0, 0);
    coin = 1'b1; step(1); coin = 1'b0;
    mode = 4'b0001; start = 1'b1; step(1); start = 1'b0;
    wait_state("rst.reach_rinse", SRinse, 2'd0, 3000);
    step(100);
    cancel = 1'b1; rst = 1'b1; step(1);
    rst = 1'b0; step(1);
    cancel = 1'b0; step(2);
    chk("rst_mid.state", int'(o_state), int'(SIdle));
    chk("rst_mid.sec_left", int'(o_sec_left), 0);
    chk("rst_mid.outputs", int'({o_waterinlet, o_motor, o_door_lock, o_paused,
                                 o_coinreturn, o_done, o_rinse_idx}), 0);

    step(5);
    chk("done_cycles", done_cycles, 2);
    chk("coinreturn_cycles", cret_cycles, 1);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/washing_machine_ctrl.md
WASHING_MACHINE_CTRL -- requirements
Module: washing_machine_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 250: i_clk frequency in Hz, one second equals CLK_HZ cycles, legal range 2 or more.
REQ-002 Parameter N_MODES, default 4: number of load modes, legal range 1..4.
REQ-003 Parameter RINSE_CYCLES, default 1: number of back-to-back rinse phases, legal range 1..4.
REQ-004 i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 i_rst  input  1  reset, synchronous and active-high.
REQ-006 i_coin  input  1  coin inserted, level-sampled each cycle.
REQ-007 i_lid  input  1  1 = lid open.
REQ-008 i_start  input  1  start request, level-sampled.
REQ-009 i_cancel  input  1  cancel request, level-sampled.
REQ-010 i_mode  input  N_MODES  one-hot load-mode select.
REQ-011 o_state  output  6  one-hot state: bit0 IDLE, bit1 READY, bit2 SOAK, bit3 WASH, bit4 RINSE, bit5 SPIN.
REQ-012 o_waterinlet  output  1  water valve open.
REQ-013 o_motor  output  1  drum motor on.
REQ-014 o_door_lock  output  1  lid latch engaged.
REQ-015 o_paused  output  1  running phase frozen by an open lid.
REQ-016 o_coinreturn  output  1  one-cycle coin-return pulse.
REQ-017 o_done  output  1  one-cycle cycle-complete pulse.
REQ-018 o_sec_left  output  11  whole seconds remaining in the current phase.
REQ-019 o_rinse_idx  output  2  zero-based index of the current rinse pass.

Function
REQ-020 IDLE moves to READY when i_coin=1, i_lid=0 and i_cancel=0; a coin arriving in any other state is ignored.
REQ-021 READY moves to SOAK when i_start=1, i_lid=0, i_cancel=0 and i_mode is nonzero.
REQ-022 READY with i_cancel=1 moves to IDLE and drives o_coinreturn=1 for exactly the first IDLE cycle.
REQ-023 The mode is latched on the READY->SOAK edge; the lowest set i_mode bit wins; later i_mode changes are ignored until the next READY.
REQ-024 Phase durations in seconds (soak/wash/rinse/spin) by mode:
- mode0: 300/600/300/300
- mode1: 480/900/480/480
- mode2: 600/1200/600/600
- mode3: 720/1500/720/720
REQ-025 On phase entry, o_sec_left loads the phase duration and the prescaler clears to 0.
REQ-026 The prescaler counts 0..CLK_HZ-1; a tick occurs at CLK_HZ-1, and each tick decrements o_sec_left.
REQ-027 The decrement that reaches 0 advances the state on the same edge; an unpaused phase therefore lasts exactly duration*CLK_HZ cycles.
REQ-028 The run sequence is SOAK->WASH->RINSE repeated RINSE_CYCLES times->SPIN->IDLE.
REQ-029 o_rinse_idx increments on each RINSE->RINSE re-entry and is 0 outside RINSE.
REQ-030 In SOAK, WASH or RINSE with i_lid=1: prescaler and o_sec_left hold, o_paused=1, o_waterinlet=0 and o_motor=0; the timer resumes from the held values when the lid closes.
REQ-031 In SPIN, o_door_lock=1 and i_lid is ignored (no pause).
REQ-032 o_waterinlet=1 in SOAK, WASH and RINSE when not paused.
REQ-033 o_motor=1 in WASH, RINSE and SPIN when not paused.
REQ-034 i_cancel=1 in any running state moves to IDLE on the next edge with no coin return and no o_done.
REQ-035 Cancel takes priority over lid, start and timer expiry; pause takes priority over a tick in the same cycle.
REQ-036 o_done=1 for exactly the first IDLE cycle after SPIN expiry.
REQ-037 o_sec_left=0 in IDLE and READY.

Reset
REQ-038 i_rst=1 forces state IDLE, clears prescaler and all counters and the latched mode, and drives every output to 0 except o_state=6'b000001, including when asserted mid-phase.
REQ-039 i_rst has priority over every other input.

Structure
REQ-040 Package washing_machine_pkg holds the state encoding constants, the 4x4 duration table, and a function returning a duration from mode and phase.
REQ-041 A single shared prescaler and second counter serve all phases; no per-phase timers.
REQ-042 Sub-module wm_phase_timer (prescaler, load, hold, tick, expiry) is instantiated once.

Verification
Bench uses CLK_HZ=2, N_MODES=4, RINSE_CYCLES=2.
REQ-043 Coin, then start with i_mode=0001 -> SOAK 600 cycles, WASH 1200, RINSE x2 each 600 with o_rinse_idx 0 then 1, SPIN 600, then o_done one cycle in IDLE.
REQ-044 Coin with lid open -> remains IDLE; coin, then cancel in READY -> IDLE and o_coinreturn exactly one cycle.
REQ-045 Lid opened for 37 cycles mid-WASH in mode2 -> o_paused high 37 cycles, valve and motor off, o_sec_left frozen, WASH lasts 2400+37 cycles.
REQ-046 Lid opened during SPIN -> o_door_lock=1, no pause, SPIN completes on schedule.
REQ-047 i_mode=0110 at start, then switched to 1000 mid-SOAK -> mode1 latched, SOAK lasts 960 cycles.
REQ-048 i_rst pulsed mid-RINSE while i_cancel=1 -> IDLE, all outputs at reset values, no o_done and no o_coinreturn.
